// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: index/counter width helpers,
// default architectural constants and the ID/EX entry layout as seen by
// neighbouring stages in the default 16-bit, 16-register configuration.
package id_pkg;

  // Register-address width for a power-of-two register count.
  function automatic int id_ra_w(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Width needed to hold 0..max_inflight pending writes.
  function automatic int id_cnt_w(input int max_inflight);
    return (max_inflight > 0) ? $clog2(max_inflight + 1) : 1;
  endfunction

  localparam int ID_SP_IDX  = 15;
  localparam int ID_DATA_W  = 16;
  localparam int ID_NREGS   = 16;
  localparam int ID_RA_W    = id_ra_w(ID_NREGS);
  localparam int ID_CTRL_W  = 16;

  // ID/EX entry in the default configuration.
  typedef struct packed {
    logic [ID_DATA_W-1:0] rs_data;
    logic [ID_DATA_W-1:0] rt_data;
    logic [ID_RA_W-1:0]   rd;
    logic                 wr_rd;
    logic [ID_CTRL_W-1:0] ctrl;
    logic [ID_DATA_W-1:0] imm;
    logic [ID_DATA_W-1:0] pc;
  } id_ex_t;

endpackage

// File: rtl/id_scoreboard.sv
// Per-register pending-write scoreboard. Each register carries a small
// saturating count of writers issued but not yet written back; sources
// with a non-zero count stall, and a destination already at the in-flight
// limit stalls. A writeback that retires the last pending write releases
// readers in the same cycle.
module id_scoreboard
  import id_pkg::*;
#(
  parameter  int NREGS        = 16,
  parameter  int MAX_INFLIGHT = 3,
  localparam int RA_W         = id_ra_w(NREGS),
  localparam int CNT_W        = id_cnt_w(MAX_INFLIGHT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs,
  input  logic [RA_W-1:0] rt,
  input  logic [RA_W-1:0] rd,
  input  logic            use_rs,
  input  logic            use_rt,
  input  logic            wr_rd,
  input  logic            issue,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            flush_en,
  input  logic [RA_W-1:0] flush_rd,
  output logic            hazard
);

  localparam int CW1 = CNT_W + 1;

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [NREGS-1:0] pend_vec;
  logic [NREGS-1:0] full_vec;

  // Increment for an issued writer, decrement for writeback and for a
  // flushed writer; decrements stack, the result floors at 0 and caps at
  // the in-flight limit.
  function automatic logic [CNT_W-1:0] next_cnt(
    input logic [CNT_W-1:0] cur,
    input logic             inc,
    input logic             dec_a,
    input logic             dec_b
  );
    logic [CW1-1:0] up;
    logic [CW1-1:0] dn;
    up = {1'b0, cur} + CW1'(inc);
    dn = CW1'(dec_a) + CW1'(dec_b);
    if (up <= dn) return '0;
    up = up - dn;
    if (up > CW1'(MAX_INFLIGHT)) return CNT_W'(MAX_INFLIGHT);
    return up[CNT_W-1:0];
  endfunction

  // Per-register pending / full flags, taking a same-cycle writeback into account.
  always_comb begin
    pend_vec = '0;
    full_vec = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend_vec[r] = (cnt[r] != '0) &&
                    !((cnt[r] == CNT_W'(1)) && wb_en && (wb_rd == RA_W'(r)));
      full_vec[r] = (cnt[r] == CNT_W'(MAX_INFLIGHT)) &&
                    !(wb_en && (wb_rd == RA_W'(r)));
    end
  end

  // Stall when a used source is pending or the destination has no free slot.
  always_comb begin
    hazard = (use_rs && pend_vec[rs]) ||
             (use_rt && pend_vec[rt]) ||
             (wr_rd  && full_vec[rd]);
  end

  // Next-count computation for every register.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = next_cnt(cnt[r],
                            issue && wr_rd && (rd == RA_W'(r)),
                            wb_en && (wb_rd == RA_W'(r)),
                            flush_en && (flush_rd == RA_W'(r)));
    end
  end

  // Counter state; async reset clears every pending count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

endmodule

// File: rtl/id_stage_sb.sv
// Decode stage: architectural register file with write-first bypass,
// pending-write scoreboard for hazard detection, and an ID/EX output
// register driven by valid/ready handshakes with flush.
module id_stage_sb
  import id_pkg::*;
#(
  parameter  int                DATA_W       = 16,
  parameter  int                NREGS        = 16,
  parameter  int                SP_IDX       = ID_SP_IDX,
  parameter  logic [DATA_W-1:0] SP_RESET     = 16'hFFFF,
  parameter  int                CTRL_W       = 16,
  parameter  int                MAX_INFLIGHT = 3,
  localparam int                RA_W         = id_ra_w(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RA_W-1:0]   rs,
  input  logic [RA_W-1:0]   rt,
  input  logic [RA_W-1:0]   rd,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              wr_rd,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [RA_W-1:0]   out_rd,
  output logic              out_wr_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc
);

  // ID/EX entry at this instance's widths.
  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [RA_W-1:0]   rd;
    logic              wr_rd;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } ex_entry_t;

  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hazard;
  logic              slot_free;
  logic              issue;
  logic              flush_en;
  ex_entry_t         ex_d;
  ex_entry_t         ex_q;

  // Register file write port; the stack pointer comes out of reset at SP_RESET.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= (r == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports with write-first bypass from the writeback bus.
  always_comb begin
    rs_val = (wb_en && (wb_rd == rs)) ? wb_data : regs[rs];
    rt_val = (wb_en && (wb_rd == rt)) ? wb_data : regs[rt];
  end

  // Only a valid held writer returns its pending count when flushed.
  assign flush_en = flush && out_valid && ex_q.wr_rd;

  id_scoreboard #(
    .NREGS        (NREGS),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .wr_rd    (wr_rd),
    .issue    (issue),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .flush_en (flush_en),
    .flush_rd (ex_q.rd),
    .hazard   (hazard)
  );

  // Handshake: accept only into a free slot, with no hazard and no flush.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = slot_free && !hazard && !flush;
    issue     = in_valid && in_ready;
  end

  // Assemble the entry loaded on issue.
  always_comb begin
    ex_d         = '0;
    ex_d.rs_data = rs_val;
    ex_d.rt_data = rt_val;
    ex_d.rd      = rd;
    ex_d.wr_rd   = wr_rd;
    ex_d.ctrl    = ctrl_in;
    ex_d.imm     = imm_in;
    ex_d.pc      = pc_in;
  end

  // ID/EX register: flush kills, issue loads, consumption empties, else hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      ex_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      ex_q      <= ex_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_rs_data = ex_q.rs_data;
  assign out_rt_data = ex_q.rt_data;
  assign out_rd      = ex_q.rd;
  assign out_wr_rd   = ex_q.wr_rd;
  assign out_ctrl    = ex_q.ctrl;
  assign out_imm     = ex_q.imm;
  assign out_pc      = ex_q.pc;

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: reset values, RAW stall with bypass,
// destination saturation, backpressure, flush and async reset mid-stall.
module tb_id_stage_sb;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rs, rt, rd;
  logic        use_rs, use_rt, wr_rd;
  logic [15:0] ctrl_in, imm_in, pc_in;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_rs_data, out_rt_data;
  logic [3:0]  out_rd;
  logic        out_wr_rd;
  logic [15:0] out_ctrl, out_imm, out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage_sb dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .use_rs      (use_rs),
    .use_rt      (use_rt),
    .wr_rd       (wr_rd),
    .ctrl_in     (ctrl_in),
    .imm_in      (imm_in),
    .pc_in       (pc_in),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rs_data (out_rs_data),
    .out_rt_data (out_rt_data),
    .out_rd      (out_rd),
    .out_wr_rd   (out_wr_rd),
    .out_ctrl    (out_ctrl),
    .out_imm     (out_imm),
    .out_pc      (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    rs = 4'd0; rt = 4'd0; rd = 4'd0;
    use_rs = 1'b0; use_rt = 1'b0; wr_rd = 1'b0;
    ctrl_in = 16'h0; imm_in = 16'h0; pc_in = 16'h0;
    wb_en = 1'b0; wb_rd = 4'd0; wb_data = 16'h0;
    flush = 1'b0;
  endtask

  task automatic instr(input logic [3:0] a_rs, input logic a_use_rs,
                       input logic [3:0] a_rt, input logic a_use_rt,
                       input logic [3:0] a_rd, input logic a_wr,
                       input logic [15:0] a_ctrl, input logic [15:0] a_imm,
                       input logic [15:0] a_pc);
    in_valid = 1'b1;
    rs = a_rs; use_rs = a_use_rs;
    rt = a_rt; use_rt = a_use_rt;
    rd = a_rd; wr_rd = a_wr;
    ctrl_in = a_ctrl; imm_in = a_imm; pc_in = a_pc;
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    rst = 1'b0;

    // Reset
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_rs_data", {16'd0, out_rs_data}, 32'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Read SP and a general register
    instr(4'd15, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 16'hA5A5, 16'h0042, 16'h0100);
    #1;
    check("rd_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("rd_out_valid", {31'd0, out_valid}, 32'd1);
    check("rd_sp", {16'd0, out_rs_data}, 32'h0000FFFF);
    check("rd_r4", {16'd0, out_rt_data}, 32'd0);
    check("rd_ctrl", {16'd0, out_ctrl}, 32'h0000A5A5);
    check("rd_pc", {16'd0, out_pc}, 32'h00000100);

    // RAW stall on r3, released by writeback with bypass
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 16'h0001, 16'h0, 16'h0102);
    tick();
    check("raw_w_rd", {28'd0, out_rd}, 32'd3);
    check("raw_w_wr", {31'd0, out_wr_rd}, 32'd1);
    instr(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0002, 16'h0, 16'h0104);
    #1;
    check("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    check("raw_drain_valid", {31'd0, out_valid}, 32'd0);
    check("raw_stall1", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 16'h1234;
    #1;
    check("raw_release", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
    check("raw_issue_valid", {31'd0, out_valid}, 32'd1);
    check("raw_bypass", {16'd0, out_rs_data}, 32'h00001234);
    #1;
    check("raw_cnt_clear", {31'd0, in_ready}, 32'd1);
    tick();
    check("raw_regfile", {16'd0, out_rs_data}, 32'h00001234);

    // Saturation on r5
    for (int i = 0; i < 3; i++) begin
      instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 16'h0010, 16'h0, 16'h0200);
      #1;
      check($sformatf("sat_w%0d", i), {31'd0, in_ready}, 32'd1);
      tick();
    end
    #1;
    check("sat_4th_stall", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 16'h0055;
    #1;
    check("sat_wb_release", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
    #1;
    check("sat_cnt_stays3", {31'd0, in_ready}, 32'd0);
    idle();

    // Writeback to a register with no pending writes
    wb_en = 1'b1; wb_rd = 4'd9; wb_data = 16'h0999;
    tick();
    wb_en = 1'b0;
    instr(4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0, 16'h0, 16'h0300);
    #1;
    check("wb0_no_pend", {31'd0, in_ready}, 32'd1);
    tick();
    check("wb0_data", {16'd0, out_rs_data}, 32'h00000999);
    idle();
    tick();

    // Backpressure
    out_ready = 1'b0;
    instr(4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 16'h00AA, 16'h1111, 16'h0400);
    tick();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    instr(4'd1, 1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 16'h00BB, 16'h2222, 16'h0404);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("bp_stall%0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp_pc%0d", i), {16'd0, out_pc}, 32'h00000400);
      check($sformatf("bp_imm%0d", i), {16'd0, out_imm}, 32'h00001111);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_b_pc", {16'd0, out_pc}, 32'h00000404);
    check("bp_b_ctrl", {16'd0, out_ctrl}, 32'h000000BB);
    idle();
    tick();

    // Flush of a held writer to r7
    out_ready = 1'b0;
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 16'h0077, 16'h0, 16'h0500);
    tick();
    check("fl_held_rd", {28'd0, out_rd}, 32'd7);
    instr(4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 16'h0078, 16'h0, 16'h0502);
    #1;
    check("fl_pre_stall", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    #1;
    check("fl_blocks_issue", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    #1;
    check("fl_cnt_clear", {31'd0, in_ready}, 32'd1);
    tick();
    check("fl_reader_valid", {31'd0, out_valid}, 32'd1);
    check("fl_reader_pc", {16'd0, out_pc}, 32'h00000502);
    out_ready = 1'b1;
    idle();
    tick();

    // Async reset while a RAW hazard on r2 is pending
    instr(4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 16'h0022, 16'h0, 16'h0600);
    tick();
    instr(4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 16'h0023, 16'h0, 16'h0602);
    #1;
    check("ar_stall", {31'd0, in_ready}, 32'd0);
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("ar_out_valid", {31'd0, out_valid}, 32'd0);
    check("ar_cnt_clear", {31'd0, in_ready}, 32'd1);
    check("ar_out_rd", {28'd0, out_rd}, 32'd0);
    check("ar_out_pc", {16'd0, out_pc}, 32'd0);
    tick();
    rst = 1'b1;
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_stage_sb.md
Name: id_stage_sb

Overview:
- Parametrised decode stage: successor to the fixed 16-bit, 16-register decode unit.
- Holds the architectural register file and replaces per-stage rd comparison with a per-register pending-write scoreboard.
- Issues decoded instructions into an ID/EX output register under valid/ready handshakes, with flush support.
- Sits between the IF/ID register and the execute stage; writeback arrives from the MEM/WB stage.

Parameters:
- DATA_W, 16, register/data width
- NREGS, 16, number of architectural registers (power of 2); RA_W = clog2(NREGS)
- SP_IDX, 15, stack-pointer register index
- SP_RESET, 16'hFFFF, stack-pointer reset value (DATA_W bits)
- CTRL_W, 16, width of opaque decoded-control bundle passed through
- MAX_INFLIGHT, 3, maximum pending writes per register; CNT_W = clog2(MAX_INFLIGHT+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle (low = stall IF)
- rs, rt, rd  in  RA_W each  source 1, source 2, destination
- use_rs, use_rt, wr_rd  in  1 each  operand-use / destination-write flags
- ctrl_in  in  CTRL_W  decoded control bundle
- imm_in  in  DATA_W  sign-extended immediate
- pc_in  in  DATA_W  program counter
- wb_en  in  1  writeback strobe
- wb_rd  in  RA_W  writeback register
- wb_data  in  DATA_W  writeback data
- flush  in  1  kill the held ID/EX entry
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  execute accepts the entry
- out_rs_data, out_rt_data  out  DATA_W each  operand values
- out_rd  out  RA_W  destination
- out_wr_rd  out  1  destination-write flag
- out_ctrl  out  CTRL_W  control bundle
- out_imm, out_pc  out  DATA_W each  immediate, PC

Behaviour:
Reset (rst low, async):
- Register file: all registers 0 except SP_IDX = SP_RESET.
- All scoreboard counters 0.
- out_valid = 0; all out_* data = 0.
- Reset asserted mid-operation discards any held entry and all pending counts.

Register file:
- 2 combinational read ports, 1 synchronous write port.
- Writes on wb_en at the clk edge.
- Write-first bypass: a read of wb_rd while wb_en is high returns wb_data.

Scoreboard:
- cnt[r] increments when an instruction with wr_rd issues to r.
- cnt[r] decrements on wb_en for r.
- Issue and writeback to the same r in the same cycle: net unchanged.
- wb_en with cnt[wb_rd] == 0 is ignored: the register is written, the counter stays 0.

Hazard, combinational on rs/rt/rd:
- pend(x) = cnt[x] != 0, except when cnt[x] == 1 and wb_en and wb_rd == x (resolves this cycle).
- hazard = (use_rs & pend(rs)) | (use_rt & pend(rt)) | (wr_rd & cnt[rd] == MAX_INFLIGHT & !(wb_en & wb_rd == rd)).

Handshake:
- slot_free = !out_valid | out_ready.
- in_ready = slot_free & !hazard & !flush.
- Issue occurs when in_valid & in_ready: at the edge, load all out_* fields and set out_valid = 1. Latency is 1 cycle from acceptance.
- If out_valid & out_ready & no issue: out_valid clears next cycle.
- While out_valid & !out_ready: all out_* fields hold stable.

Flush:
- At the edge: out_valid = 0.
- If the held entry was valid with out_wr_rd, decrement cnt[out_rd]. This combines additively with a same-cycle wb decrement of the same register, floored at 0.
- flush blocks issue that cycle.
- flush with out_valid = 0 is a no-op.

Counters never exceed MAX_INFLIGHT and never go negative.

Decomposition:
- Package id_pkg: RA_W/CNT_W derivation functions, SP_IDX default, the id_ex_t struct (rs_data, rt_data, rd, wr_rd, ctrl, imm, pc).
- One sub-module: id_scoreboard (per-register counters, pend/hazard logic, inc/dec/flush inputs).
- The register file stays inline in id_stage_sb.

Test Plan:
- Reset: rst low for 2 cycles, then high → read SP_IDX = 16'hFFFF, other registers 0, out_valid = 0, in_ready = 1.
- RAW stall: issue wr_rd rd=3; next instruction with use_rs rs=3 → in_ready = 0 until wb_en wb_rd=3 wb_data=16'h1234. In that wb cycle in_ready = 1 and out_rs_data = 16'h1234 on the next edge.
- Saturation: issue 3 writers to r5 with no writeback → 4th writer to r5 stalls. A wb to r5 in the same cycle releases it the same cycle, and cnt stays 3.
- Backpressure: out_ready = 0 with out_valid = 1 → out_* fields stable for 4 cycles and in_ready = 0. out_ready = 1 → new instruction loads on the next edge.
- Flush: held entry wr_rd rd=7 (cnt=1), flush=1 → out_valid = 0 and cnt[7] = 0. A reader of r7 issues without stall the next cycle.
- Async reset mid-stall: pull rst low between edges while a hazard is pending → out_valid = 0 and all counters 0 immediately, without waiting for a clock edge.
